// File: rtl/conv_layer_sched_pkg.sv
// Shared widths, descriptor layout and sequencer states for conv_layer_sched.
package conv_layer_sched_pkg;

   localparam int TENSOR_SIZE_W = 8;
   localparam int KERNEL_SIZE_W = 4;
   localparam int CHANNELS_W    = 8;
   localparam int STRIDE_W      = 4;
   localparam int KERNEL_NUMS_W = 8;
   localparam int ADDR_W        = 16;

   // First member is the MSB: tensor_size sits in the low bits of a descriptor word.
   typedef struct packed {
      logic [ADDR_W-1:0]        tensor_base;
      logic [ADDR_W-1:0]        weight_base;
      logic [ADDR_W-1:0]        result_base;
      logic [KERNEL_NUMS_W-1:0] kernel_nums;
      logic [STRIDE_W-1:0]      stride;
      logic [CHANNELS_W-1:0]    channels;
      logic [KERNEL_SIZE_W-1:0] kernel_size;
      logic [TENSOR_SIZE_W-1:0] tensor_size;
   } desc_t;

   localparam int DESC_W = $bits(desc_t);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_START,
      S_RUN,
      S_NEXT,
      S_FIN
   } sched_state_e;

endpackage

// File: rtl/conv_desc_ram.sv
// Descriptor store: one write port, one registered read port.
module conv_desc_ram #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = 80
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/conv_layer_sched.sv
// Descriptor-driven layer sequencer for the img2col/GEMM conv engine.
// Optional RUN-state watchdog enabled by defining CONV_SCHED_WDOG_EN.
module conv_layer_sched
   import conv_layer_sched_pkg::*;
#(
   parameter int DESC_DEPTH  = 8,
   parameter int IDX_W       = 3,
   parameter int WDOG_CYCLES = 2**20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_idx,
   input  logic [DESC_W-1:0]        cfg_wdata,
   input  logic [IDX_W:0]           num_layers,
   input  logic                     go,
   input  logic                     abort,
   output logic                     acc_start,
   input  logic                     acc_w_done,
   output logic [TENSOR_SIZE_W-1:0] tensor_size,
   output logic [KERNEL_SIZE_W-1:0] kernel_size,
   output logic [CHANNELS_W-1:0]    channels,
   output logic [STRIDE_W-1:0]      stride,
   output logic [KERNEL_NUMS_W-1:0] kernel_nums,
   output logic [ADDR_W-1:0]        tensor_base,
   output logic [ADDR_W-1:0]        weight_base,
   output logic [ADDR_W-1:0]        result_base,
   output logic                     busy,
   output logic [IDX_W-1:0]         layer_idx,
   output logic                     seq_done,
   output logic                     aborted,
   output logic                     cfg_err,
   output logic                     wdog_err
);

   sched_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W:0]    n_layers_q;
   logic [IDX_W:0]    last_idx;
   logic              rd_en;
   logic [IDX_W-1:0]  rd_addr;
   logic [DESC_W-1:0] rd_data;
   desc_t             rd_desc;
   logic              ram_we;
   logic              go_accept;
   logic              abort_hit;
   logic              wdog_fire;

   assign busy      = (state_q != S_IDLE);
   assign layer_idx = idx_q;
   assign go_accept = go && (state_q == S_IDLE);
   assign abort_hit = abort && busy;
   assign ram_we    = cfg_we && !busy && (int'(cfg_idx) < DESC_DEPTH);
   // One bit wider than the index so num_layers == DESC_DEPTH never wraps.
   assign last_idx  = n_layers_q - 1'b1;
   assign rd_desc   = desc_t'(rd_data);

   conv_desc_ram #(
      .DEPTH (DESC_DEPTH),
      .AW    (IDX_W),
      .W     (DESC_W)
   ) u_desc_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (cfg_idx),
      .wdata (cfg_wdata),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_start = 1'b0;
      seq_done  = 1'b0;
      case (state_q)
         S_IDLE:   if (go) begin
                      idx_d   = '0;
                      state_d = (num_layers == '0) ? S_FIN : S_LOAD;
                   end
         S_LOAD:   state_d = S_SETTLE;
         S_SETTLE: state_d = S_START;
         S_START:  begin
                      acc_start = 1'b1;
                      state_d   = S_RUN;
                   end
         S_RUN:    if (acc_w_done)     state_d = S_NEXT;
                   else if (wdog_fire) state_d = S_IDLE;
         S_NEXT:   if ({1'b0, idx_q} == last_idx) begin
                      state_d = S_FIN;
                   end else begin
                      idx_d   = idx_q + 1'b1;
                      state_d = S_LOAD;
                   end
         S_FIN:    begin
                      seq_done = 1'b1;
                      state_d  = S_IDLE;
                   end
         default:  state_d = S_IDLE;
      endcase
      if (abort_hit) begin
         state_d   = S_IDLE;
         idx_d     = idx_q;
         acc_start = 1'b0;
         seq_done  = 1'b0;
      end
   end

   // Read is issued on the way into LOAD so the descriptor is ready to register in LOAD.
   assign rd_en   = (state_d == S_LOAD);
   assign rd_addr = idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         n_layers_q  <= '0;
         aborted     <= 1'b0;
         cfg_err     <= 1'b0;
         tensor_size <= '0;
         kernel_size <= '0;
         channels    <= '0;
         stride      <= '0;
         kernel_nums <= '0;
         tensor_base <= '0;
         weight_base <= '0;
         result_base <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         aborted <= abort_hit;
         cfg_err <= cfg_we && busy;
         if (go_accept) n_layers_q <= num_layers;
         if (state_q == S_LOAD && !abort_hit) begin
            tensor_size <= rd_desc.tensor_size;
            kernel_size <= rd_desc.kernel_size;
            channels    <= rd_desc.channels;
            stride      <= rd_desc.stride;
            kernel_nums <= rd_desc.kernel_nums;
            tensor_base <= rd_desc.tensor_base;
            weight_base <= rd_desc.weight_base;
            result_base <= rd_desc.result_base;
         end
      end
   end

`ifdef CONV_SCHED_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

   logic [WD_W-1:0] wd_cnt_q;
   logic            wdog_err_q;

   assign wdog_fire = (state_q == S_RUN) && (wd_cnt_q == WD_W'(WDOG_CYCLES - 1));
   assign wdog_err  = wdog_err_q;

   // Held at zero outside RUN, so every RUN entry starts a fresh count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q   <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (state_q != S_RUN) wd_cnt_q <= '0;
         else                  wd_cnt_q <= wd_cnt_q + 1'b1;
         if (go_accept)                                 wdog_err_q <= 1'b0;
         else if (wdog_fire && !acc_w_done && !abort)   wdog_err_q <= 1'b1;
      end
   end
`else
   assign wdog_fire = 1'b0;
   assign wdog_err  = 1'b0;
`endif

endmodule
